// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch-stage sequencer driving the PC register and the imem req/gnt/rvalid port
// Optional build macro: IFETCH_ALIGN_CHK_EN (adds misalign_o, suppresses misaligned non-trap targets)
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   pc_addr_i                         current PC from the PC register
//   trap_*/br_*/jmp_*                 redirect sources, priority trap > branch > jump
//   imem_req_o/addr_o/gnt_i/rvalid_i/rdata_i   instruction memory port, one request in flight
//   inst_o, inst_valid_o, id_ready_i  instruction handoff to ID
//   jump_en_o, jump_addr_o, pipeline_stall_o   PC register control
//   flush_o                           kill younger instructions in IF/ID
//   misalign_o                        misaligned redirect target dropped (IFETCH_ALIGN_CHK_EN only)
module ifetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr_i,
    input  logic              trap_en_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              br_en_i,
    input  logic [ADDR_W-1:0] br_addr_i,
    input  logic              jmp_en_i,
    input  logic [ADDR_W-1:0] jmp_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    input  logic              id_ready_i,
    output logic              jump_en_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              pipeline_stall_o,
    output logic              flush_o
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    output logic              misalign_o
`endif
);
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]        state, state_nx;
    logic              pend_vld, pend_vld_nx;
    logic [ADDR_W-1:0] pend_addr;
    logic [1:0]        pend_prio;
    logic [INST_W-1:0] inst_buf;
    logic              any_req, red, bad, take_new, latch, redir_rv, wait_s;
    logic [ADDR_W-1:0] new_addr;
    logic [1:0]        new_prio;

    always_comb begin
        any_req  = trap_en_i | br_en_i | jmp_en_i;
        new_addr = trap_en_i ? trap_addr_i : br_en_i ? br_addr_i : jmp_addr_i;
        new_prio = trap_en_i ? 2'd3 : br_en_i ? 2'd2 : 2'd1;
`ifdef IFETCH_ALIGN_CHK_EN
        // trap targets always go through; other misaligned winners are ignored entirely
        bad      = any_req & ~trap_en_i & (new_addr[1:0] != 2'b00);
`else
        bad      = 1'b0;
`endif
        red      = any_req & ~bad;
        wait_s   = state == WAIT;
        // equal or higher priority replaces the pending redirect, lower is dropped
        take_new = red & (~pend_vld | (new_prio >= pend_prio));
        latch    = wait_s & ~imem_rvalid_i & take_new;
        redir_rv = wait_s & imem_rvalid_i & (pend_vld | red);
        jump_en_o        = (red & ~wait_s) | redir_rv;
        jump_addr_o      = take_new ? new_addr : pend_addr;
        flush_o          = jump_en_o | latch;
        imem_req_o       = (state == FETCH) & ~red;
        imem_addr_o      = pc_addr_i;
        inst_valid_o     = (wait_s & imem_rvalid_i & ~pend_vld & ~red) | ((state == HOLD) & ~red);
        inst_o           = (state == HOLD) ? inst_buf : imem_rdata_i;
        pipeline_stall_o = ~(inst_valid_o & id_ready_i);
        pend_vld_nx      = redir_rv ? 1'b0 : latch ? 1'b1 : pend_vld;
        state_nx = jump_en_o        ? FETCH :
                   state == BOOT    ? FETCH :
                   state == FETCH   ? (imem_gnt_i ? WAIT : FETCH) :
                   wait_s           ? (imem_rvalid_i ? (id_ready_i ? FETCH : HOLD) : WAIT) :
                                      (id_ready_i ? FETCH : HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_prio <= 2'd0;
            inst_buf  <= '0;
        end else begin
            state    <= state_nx;
            pend_vld <= pend_vld_nx;
            if (latch) begin
                pend_addr <= new_addr;
                pend_prio <= new_prio;
            end
            if (wait_s & imem_rvalid_i)
                inst_buf <= imem_rdata_i;
        end
    end

`ifdef IFETCH_ALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_o <= 1'b0;
        else
            misalign_o <= bad;
    end
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed self-checking bench for ifetch_ctrl with a PC register model
module tb_ifetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        trap_en, br_en, jmp_en;
  logic [31:0] trap_addr, br_addr, jmp_addr;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, inst;
  logic        inst_valid, id_ready, jump_en, stall, flush;
  logic [31:0] jump_addr;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  ifetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_addr_i(pc),
    .trap_en_i(trap_en), .trap_addr_i(trap_addr),
    .br_en_i(br_en), .br_addr_i(br_addr),
    .jmp_en_i(jmp_en), .jmp_addr_i(jmp_addr),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .inst_o(inst), .inst_valid_o(inst_valid), .id_ready_i(id_ready),
    .jump_en_o(jump_en), .jump_addr_o(jump_addr),
    .pipeline_stall_o(stall), .flush_o(flush)
  );
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h0;
    else if (jump_en) pc <= jump_addr;
    else if (!stall) pc <= pc + 32'd4;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd, input logic rdy);
    @(negedge clk);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; id_ready = rdy;
    trap_en = 1'b0; br_en = 1'b0; jmp_en = 1'b0;
    trap_addr = 32'h0; br_addr = 32'h0; jmp_addr = 32'h0;
  endtask
  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    trap_en = 1'b0; br_en = 1'b0; jmp_en = 1'b0;
    trap_addr = 32'h0; br_addr = 32'h0; jmp_addr = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_stall", stall, 1'b1);
    chk("rst_jump", jump_en, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    cyc(1, 0, 0, 1); rst = 1'b0; #1;
    chk("boot_req", imem_req, 1'b0);
    chk("boot_stall", stall, 1'b1);
    cyc(1, 0, 0, 1); #1;
    chk("f0_req", imem_req, 1'b1);
    chk("f0_addr", imem_addr, 32'h0);
    chk("f0_stall", stall, 1'b1);
    cyc(1, 1, 32'h11111111, 1); #1;
    chk("w0_valid", inst_valid, 1'b1);
    chk("w0_inst", inst, 32'h11111111);
    chk("w0_stall", stall, 1'b0);
    chk("w0_req", imem_req, 1'b0);
    cyc(1, 0, 0, 1); #1;
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_req", imem_req, 1'b1);
    cyc(1, 1, 32'h22222222, 1); #1;
    chk("w1_stall", stall, 1'b0);
    cyc(1, 0, 0, 1); #1;
    chk("f2_addr", imem_addr, 32'h8);
    cyc(1, 1, 32'h00500093, 0); #1;
    chk("h0_valid", inst_valid, 1'b1);
    chk("h0_stall", stall, 1'b1);
    cyc(1, 0, 32'hdeadbeef, 0); #1;
    chk("h1_inst", inst, 32'h00500093);
    chk("h1_valid", inst_valid, 1'b1);
    chk("h1_stall", stall, 1'b1);
    chk("h1_req", imem_req, 1'b0);
    cyc(1, 0, 32'hdeadbeef, 0); #1;
    chk("h2_inst", inst, 32'h00500093);
    cyc(1, 0, 32'hdeadbeef, 1); #1;
    chk("h3_inst", inst, 32'h00500093);
    chk("h3_stall", stall, 1'b0);
    cyc(1, 0, 0, 1); #1;
    chk("f3_addr", imem_addr, 32'hc);
    chk("f3_req", imem_req, 1'b1);
    cyc(1, 0, 0, 1); br_en = 1'b1; br_addr = 32'h100; #1;
    chk("br_flush", flush, 1'b1);
    chk("br_jump", jump_en, 1'b0);
    cyc(1, 0, 0, 1); #1;
    chk("br_wait_flush", flush, 1'b0);
    chk("br_wait_jump", jump_en, 1'b0);
    cyc(1, 1, 32'h33333333, 1); #1;
    chk("br_rv_valid", inst_valid, 1'b0);
    chk("br_rv_jump", jump_en, 1'b1);
    chk("br_rv_addr", jump_addr, 32'h100);
    cyc(1, 0, 0, 1); #1;
    chk("br_tgt_addr", imem_addr, 32'h100);
    trap_en = 1'b1; trap_addr = 32'h80; br_en = 1'b1; br_addr = 32'h100;
    jmp_en = 1'b1; jmp_addr = 32'h200; #1;
    chk("pri_addr", jump_addr, 32'h80);
    chk("pri_jump", jump_en, 1'b1);
    chk("pri_flush", flush, 1'b1);
    chk("pri_req", imem_req, 1'b0);
    cyc(1, 0, 0, 1); #1;
    chk("trap_tgt_addr", imem_addr, 32'h80);
    cyc(1, 0, 0, 1); jmp_en = 1'b1; jmp_addr = 32'h200; #1;
    chk("pj_flush", flush, 1'b1);
    chk("pj_jump", jump_en, 1'b0);
    cyc(1, 0, 0, 1); trap_en = 1'b1; trap_addr = 32'h80; #1;
    chk("pt_flush", flush, 1'b1);
    chk("pt_jump", jump_en, 1'b0);
    cyc(1, 0, 0, 1); jmp_en = 1'b1; jmp_addr = 32'h300; #1;
    chk("pd_jump", jump_en, 1'b0);
    cyc(1, 1, 32'h44444444, 1); #1;
    chk("pend_jump", jump_en, 1'b1);
    chk("pend_addr", jump_addr, 32'h80);
    chk("pend_valid", inst_valid, 1'b0);
    cyc(1, 0, 0, 1); #1;
    chk("pend_tgt_addr", imem_addr, 32'h80);
    cyc(1, 0, 0, 1); rst = 1'b1; #1;
    chk("mrst_req", imem_req, 1'b0);
    chk("mrst_stall", stall, 1'b1);
    cyc(1, 1, 32'h55555555, 1); rst = 1'b0; #1;
    chk("stale_valid", inst_valid, 1'b0);
    chk("stale_jump", jump_en, 1'b0);
    chk("stale_req", imem_req, 1'b0);
    cyc(1, 0, 0, 1); #1;
    chk("rf_req", imem_req, 1'b1);
    chk("rf_addr", imem_addr, 32'h0);
    chk("rf_valid", inst_valid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
